// File: rtl/seg7_scan_ndigit.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ndigit
// Summary  : N-digit multiplexed BCD seven-segment scanner with frame-synchronous
//            shadow load, per-digit dp, ghost guard and pin polarity control.
//            Optional digit blink enabled by defining SEG7_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ndigit #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int GHOST_GUARD    = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 0
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 50
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  output logic                    busy,
  output logic                    frame_done,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel
`ifdef SEG7_BLINK_EN
  ,
  input  logic [NUM_DIGITS-1:0]   blink_mask
`endif
);

  localparam int c_PW = $clog2(REFRESH_DIV);
  localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(REFRESH_DIV - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);
  localparam logic [31:0]     c_ON_CYCLES  = 32'(REFRESH_DIV - GHOST_GUARD);
  localparam logic            c_SEG_INV    = (SEG_ACTIVE_LOW != 0);
  localparam logic            c_SEL_INV    = (SEL_ACTIVE_LOW != 0);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("seg7_scan_ndigit: NUM_DIGITS must be 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("seg7_scan_ndigit: REFRESH_DIV must be >= 2");
    end
    if (GHOST_GUARD < 0 || GHOST_GUARD >= REFRESH_DIV) begin : g_bad_ghost_guard
      $error("seg7_scan_ndigit: GHOST_GUARD must be 0..REFRESH_DIV-1");
    end
    if (SEG_ACTIVE_LOW < 0 || SEG_ACTIVE_LOW > 1 || SEL_ACTIVE_LOW < 0 || SEL_ACTIVE_LOW > 1)
    begin : g_bad_polarity
      $error("seg7_scan_ndigit: polarity parameters must be 0 or 1");
    end
  endgenerate

  logic [c_PW-1:0]         r_presc;
  logic [c_IW-1:0]         r_idx;
  logic                    r_pending;
  logic                    r_frame_done;
  logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_sel;

  logic                    w_tick;
  logic                    w_boundary;
  logic                    w_sel_on;
  logic                    w_blank;
  logic                    w_mask_bit;
  logic [3:0]              w_nibble;
  logic                    w_dp_bit;
  logic [NUM_DIGITS-1:0]   w_sel_raw;
  logic [6:0]              w_seg_lit;
  logic                    w_dp_lit;

  assign w_tick     = (r_presc == c_PRESC_LAST);
  assign w_boundary = w_tick && (r_idx == c_IDX_LAST);
  assign w_sel_on   = (32'(r_presc) < c_ON_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_shadow_bcd <= '1;
      r_shadow_dp  <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
      if (w_tick) begin
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IW'(1);
      end
      // A load arriving on the boundary cycle itself is captured immediately.
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (r_pending || load) begin
          r_shadow_bcd <= bcd;
          r_shadow_dp  <= dp_mask;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
      r_frame_done <= w_boundary;
    end
  end

  always_comb begin
    w_nibble   = 4'hF;
    w_dp_bit   = 1'b0;
    w_mask_bit = 1'b0;
    w_sel_raw  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == c_IW'(k)) begin
        w_nibble     = r_shadow_bcd[k*4 +: 4];
        w_dp_bit     = r_shadow_dp[k];
        w_sel_raw[k] = w_sel_on;
`ifdef SEG7_BLINK_EN
        w_mask_bit   = blink_mask[k];
`endif
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int c_BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_FRAMES - 1);

  generate
    if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
      $error("seg7_scan_ndigit: BLINK_FRAMES must be >= 1");
    end
  endgenerate

  logic [c_BW-1:0] r_blink_cnt;
  logic            r_blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_boundary) begin
      if (r_blink_cnt == c_BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_BW'(1);
      end
    end
  end

  assign w_blank = r_blink_phase && w_mask_bit;
`else
  assign w_blank = 1'b0 & w_mask_bit;
`endif

  always_comb begin
    case (w_nibble)
      4'd0:    w_seg_lit = 7'h3F;
      4'd1:    w_seg_lit = 7'h06;
      4'd2:    w_seg_lit = 7'h5B;
      4'd3:    w_seg_lit = 7'h4F;
      4'd4:    w_seg_lit = 7'h66;
      4'd5:    w_seg_lit = 7'h6D;
      4'd6:    w_seg_lit = 7'h7D;
      4'd7:    w_seg_lit = 7'h07;
      4'd8:    w_seg_lit = 7'h7F;
      4'd9:    w_seg_lit = 7'h6F;
      default: w_seg_lit = 7'h00;
    endcase
    if (w_blank) begin
      w_seg_lit = 7'h00;
    end
  end

  assign w_dp_lit = w_dp_bit && w_sel_on && !w_blank;

  // Pins are registered so the scan position and the pattern change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= {7{c_SEG_INV}};
      r_dp  <= c_SEG_INV;
      r_sel <= {NUM_DIGITS{c_SEL_INV}};
    end else begin
      r_seg <= w_seg_lit ^ {7{c_SEG_INV}};
      r_dp  <= w_dp_lit ^ c_SEG_INV;
      r_sel <= w_sel_raw ^ {NUM_DIGITS{c_SEL_INV}};
    end
  end

  assign busy       = r_pending;
  assign frame_done = r_frame_done;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign digit_sel  = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ndigit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ndigit
// Summary  : Self-checking bench for seg7_scan_ndigit (4 digits, 4-cycle slots,
//            1-cycle ghost guard, active-low segments, active-high selects).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ndigit;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GG = 1;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        load    = 1'b0;
  logic [15:0] bcd     = 16'h0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic        busy, frame_done, dp;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position is derived from the cycle count since reset.
  int          m_n;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic        m_pending;
  logic        m_fd;
  int          out_idx, out_presc;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpm;
    int          slot;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  sel;
  } vec_t;
  vec_t tbl[8];

  seg7_scan_ndigit #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GHOST_GUARD(GG),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .dp_mask(dp_mask), .load(load),
    .busy(busy), .frame_done(frame_done), .seg(seg), .dp(dp), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] lit_segs(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B; 4'd3: return 7'h4F;
      4'd4: return 7'h66; 4'd5: return 7'h6D; 4'd6: return 7'h7D; 4'd7: return 7'h07;
      4'd8: return 7'h7F; 4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_bcd = 16'hFFFF; m_dp = 4'b0000; m_pending = 1'b0; m_fd = 1'b0;
    out_idx = 0; out_presc = 0;
  endtask

  // One clock: predict the post-edge outputs, clock, then compare.
  task automatic step();
    int presc, idx;
    logic on, bnd, e_dp, e_busy;
    logic [3:0] nib, e_sel;
    logic [6:0] e_seg;
    presc  = m_n % RD;
    idx    = (m_n / RD) % ND;
    on     = presc < (RD - GG);
    nib    = 4'(m_bcd >> (4 * idx));
    e_seg  = ~lit_segs(nib);
    e_dp   = ~(on && m_dp[idx]);
    e_sel  = on ? 4'(1 << idx) : 4'b0000;
    bnd    = (presc == RD - 1) && (idx == ND - 1);
    e_busy = !bnd && (m_pending || load);
    if (bnd && (m_pending || load)) begin
      m_bcd = bcd;
      m_dp  = dp_mask;
    end
    @(posedge clk);
    #1;
    chk("seg", {25'd0, seg}, {25'd0, e_seg});
    chk("dp", {31'd0, dp}, {31'd0, e_dp});
    chk("digit_sel", {28'd0, digit_sel}, {28'd0, e_sel});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("frame_done", {31'd0, frame_done}, {31'd0, bnd});
    m_pending = e_busy;
    m_n++;
    out_idx   = idx;
    out_presc = presc;
    m_fd      = bnd;
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      step();
      k++;
    end while (!m_fd && k < 40);
    checks++;
    if (!m_fd) begin
      errors++;
      $display("FAIL wait_frame timeout steps=%0d limit=40", k);
    end
  endtask

  task automatic goto_slot(input int slot);
    int k = 0;
    do begin
      step();
      k++;
    end while (!(out_idx == slot && out_presc == 0) && k < 20);
    checks++;
    if (!(out_idx == slot && out_presc == 0)) begin
      errors++;
      $display("FAIL goto_slot timeout slot=%0d steps=%0d", slot, k);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] m);
    bcd = v; dp_mask = m; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int fd_count;
    tbl[0] = '{16'h1234, 4'b0000, 0, 7'b0011001, 1'b1, 4'b0001};
    tbl[1] = '{16'h1234, 4'b0000, 3, 7'b1111001, 1'b1, 4'b1000};
    tbl[2] = '{16'hA000, 4'b0100, 3, 7'h7F,      1'b1, 4'b1000};
    tbl[3] = '{16'hA000, 4'b0100, 2, 7'b1000000, 1'b0, 4'b0100};
    tbl[4] = '{16'h5678, 4'b0001, 0, 7'b0000000, 1'b0, 4'b0001};
    tbl[5] = '{16'h5678, 4'b0001, 1, 7'b1111000, 1'b1, 4'b0010};
    tbl[6] = '{16'h9FC2, 4'b1000, 0, 7'b0100100, 1'b1, 4'b0001};
    tbl[7] = '{16'h9FC2, 4'b1000, 3, 7'b0010000, 1'b0, 4'b1000};

    // Reset state
    model_reset();
    #12;
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_sel", {28'd0, digit_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load 1234: busy until boundary, then "4" in slot 0 for 3 cycles plus ghost
    step();
    pulse_load(16'h1234, 4'b0000);
    chk("busy_after_load", {31'd0, busy}, 32'd1);
    wait_frame();
    step();
    chk("slot0_seg_4", {25'd0, seg}, 32'h19);
    chk("slot0_sel_c0", {28'd0, digit_sel}, 32'h1);
    step();
    chk("slot0_sel_c1", {28'd0, digit_sel}, 32'h1);
    step();
    chk("slot0_sel_c2", {28'd0, digit_sel}, 32'h1);
    step();
    chk("slot0_ghost", {28'd0, digit_sel}, 32'h0);

    // Free run: exactly one frame_done per 16 cycles
    fd_count = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      fd_count += int'(frame_done);
    end
    chk("frame_done_per_48", fd_count, 32'd3);

    // Input change without load must not reach the display
    bcd = 16'h9999;
    wait_frame();
    goto_slot(0);
    chk("no_load_unchanged", {25'd0, seg}, 32'h19);
    // Two loads before one boundary: the last inputs win
    wait_frame();
    pulse_load(16'h5555, 4'b0000);
    step();
    pulse_load(16'h6666, 4'b0000);
    wait_frame();
    step();
    chk("last_load_wins", {25'd0, seg}, 32'h02);

    // Table of directed captures
    for (int i = 0; i < 8; i++) begin
      pulse_load(tbl[i].bcd, tbl[i].dpm);
      wait_frame();
      goto_slot(tbl[i].slot);
      chk($sformatf("tbl%0d_seg", i), {25'd0, seg}, {25'd0, tbl[i].seg});
      chk($sformatf("tbl%0d_dp", i), {31'd0, dp}, {31'd0, tbl[i].dp});
      chk($sformatf("tbl%0d_sel", i), {28'd0, digit_sel}, {28'd0, tbl[i].sel});
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) bcd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) dp_mask = 4'($urandom);
      step();
    end
    load = 1'b0;

    // Asynchronous reset mid-slot 2
    pulse_load(16'h8888, 4'b1111);
    wait_frame();
    goto_slot(2);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_dp", {31'd0, dp}, 32'd1);
    chk("async_rst_sel", {28'd0, digit_sel}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("restart_sel", {28'd0, digit_sel}, 32'h1);
    chk("restart_blank", {25'd0, seg}, 32'h7F);
    for (int i = 0; i < 16; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
